// File: rtl/cpu_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one-cycle-latency reads to
// instruction memory and buffers returned words in a small prefetch FIFO.
module cpu_fetch_unit #(
   parameter int ADDR_W = 8,
   parameter int INSTR_W = 19,
   parameter int DEPTH = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               reset,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               redirect,
   input  logic [ADDR_W-1:0]  redirect_pc,
   input  logic               halt,
   output logic               instr_valid,
   output logic [INSTR_W-1:0] instr,
   output logic [ADDR_W-1:0]  instr_pc,
   input  logic               instr_ready
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [ADDR_W-1:0]  pc_r;
   logic               inflight_r;
   logic [ADDR_W-1:0]  inflight_pc_r;
   logic [INSTR_W-1:0] data_mem_r [DEPTH];
   logic [ADDR_W-1:0]  pc_mem_r [DEPTH];
   logic [PTR_W-1:0]   rd_ptr_r;
   logic [PTR_W-1:0]   wr_ptr_r;
   logic [CNT_W-1:0]   count_r;

   logic               valid_s;
   logic               pop_s;
   logic               push_s;
   logic               issue_s;
   logic [CNT_W-1:0]   occ_s;

   // Handshake and issue decisions; occupancy counts the outstanding fetch so
   // the FIFO can never overflow. A response arriving during redirect is dropped.
   always_comb begin
      valid_s = (count_r != '0);
      pop_s   = valid_s && instr_ready;
      push_s  = inflight_r && !redirect;
      occ_s   = count_r + CNT_W'(inflight_r) - CNT_W'(pop_s);
      issue_s = !reset && !halt && !redirect && (occ_s < CNT_W'(DEPTH));
   end

   // Head presentation, forced to zero while the FIFO is empty.
   always_comb begin
      instr = '0;
      instr_pc = '0;
      if (valid_s) begin
         instr = data_mem_r[rd_ptr_r];
         instr_pc = pc_mem_r[rd_ptr_r];
      end else begin
         instr = '0;
         instr_pc = '0;
      end
   end

   assign instr_valid = valid_s;
   assign imem_req    = issue_s;
   assign imem_addr   = pc_r;

   // Program counter and outstanding-fetch tracking.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_r <= RESET_PC;
         inflight_r <= 1'b0;
         inflight_pc_r <= '0;
      end else begin
         inflight_r <= issue_s;
         inflight_pc_r <= pc_r;
         if (redirect) begin
            pc_r <= redirect_pc;
         end else if (issue_s) begin
            pc_r <= pc_r + ADDR_W'(1);
         end
      end
   end

   // FIFO pointers and occupancy; redirect flushes after any same-cycle transfer.
   always_ff @(posedge clk) begin
      if (reset || redirect) begin
         rd_ptr_r <= '0;
         wr_ptr_r <= '0;
         count_r <= '0;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         count_r <= count_r + CNT_W'(push_s) - CNT_W'(pop_s);
      end
   end

   // FIFO storage; contents are only observable through valid head entries.
   always_ff @(posedge clk) begin
      if (!reset && push_s) begin
         data_mem_r[wr_ptr_r] <= imem_rdata;
         pc_mem_r[wr_ptr_r] <= inflight_pc_r;
      end
   end

endmodule

// File: tb/tb_cpu_fetch_unit.sv
// Self-checking bench for cpu_fetch_unit: directed latency/backpressure/redirect/
// halt/reset scenarios plus a randomized run against a queue-based model.
module tb_cpu_fetch_unit;

   localparam int DEPTH = 4;
   localparam logic [7:0] RPC = 8'hFE;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req;
   logic [7:0]  imem_addr;
   logic [18:0] imem_rdata;
   logic        redirect;
   logic [7:0]  redirect_pc;
   logic        halt;
   logic        instr_valid;
   logic [18:0] instr;
   logic [7:0]  instr_pc;
   logic        instr_ready;

   int tests = 0;
   int fails = 0;

   cpu_fetch_unit #(.ADDR_W(8), .INSTR_W(19), .DEPTH(DEPTH), .RESET_PC(RPC)) dut (
      .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rdata(imem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
      .halt(halt), .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
      .instr_ready(instr_ready)
   );

   always #5 clk = ~clk;

   function automatic logic [18:0] word(input logic [7:0] a);
      return {11'd0, a} + 19'd100;
   endfunction

   // Synchronous instruction memory; returns junk when not requested.
   always @(posedge clk) imem_rdata <= imem_req ? word(imem_addr) : 19'h7FFFF;

   task automatic drive(input logic r, input logic rdy, input logic h,
                        input logic rd, input logic [7:0] rpc);
      @(negedge clk);
      reset = r; instr_ready = rdy; halt = h; redirect = rd; redirect_pc = rpc;
      #1;
   endtask

   task automatic test_reset();
      logic [7:0] e;
      for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
      tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL reset_req: got %b want 0", imem_req); end
      tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
      tests++; if (instr !== 19'd0 || instr_pc !== 8'd0) begin fails++; $display("FAIL reset_head: got %h/%h want 0/0", instr, instr_pc); end
      // first request in first cycle out of reset, data 2 cycles later, wraps at 0xFF
      for (int i = 0; i < 6; i++) begin
         drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
         e = RPC + 8'(i);
         tests++; if (imem_req !== 1'b1 || imem_addr !== e) begin fails++; $display("FAIL start_req[%0d]: got %b/%h want 1/%h", i, imem_req, imem_addr, e); end
         tests++; if (instr_valid !== (i >= 2)) begin fails++; $display("FAIL start_valid[%0d]: got %b want %b", i, instr_valid, i >= 2); end
         if (i >= 2) begin
            e = RPC + 8'(i - 2);
            tests++; if (instr_pc !== e || instr !== word(e)) begin fails++; $display("FAIL start_head[%0d]: got %h/%h want %h/%h", i, instr, instr_pc, word(e), e); end
         end
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] e;
      for (int i = 0; i < 10; i++) begin
         drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
         tests++; if (instr_valid !== 1'b1 || instr_pc !== 8'h02 || instr !== word(8'h02)) begin fails++; $display("FAIL bp_hold[%0d]: got %b %h/%h want 1 %h/02", i, instr_valid, instr, instr_pc, word(8'h02)); end
         tests++; if (imem_req !== (i < 2)) begin fails++; $display("FAIL bp_req[%0d]: got %b want %b", i, imem_req, i < 2); end
      end
      for (int j = 0; j < 10; j++) begin
         drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
         e = 8'h02 + 8'(j);
         if (j == 0) begin
            tests++; if (imem_req !== 1'b1 || imem_addr !== 8'h06) begin fails++; $display("FAIL bp_resume_req: got %b/%h want 1/06", imem_req, imem_addr); end
         end
         tests++; if (instr_valid !== 1'b1 || instr_pc !== e || instr !== word(e)) begin fails++; $display("FAIL bp_drain[%0d]: got %b %h/%h want 1 %h/%h", j, instr_valid, instr, instr_pc, word(e), e); end
      end
   endtask

   task automatic test_redirect();
      logic [7:0] e;
      // FIFO holds 0C,0D,0E with 0F in flight
      drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h40);
      tests++; if (instr_valid !== 1'b1 || instr_pc !== 8'h0C || imem_req !== 1'b0) begin fails++; $display("FAIL redir_R: got v%b pc%h req%b want v1 pc0c req0", instr_valid, instr_pc, imem_req); end
      for (int k = 1; k <= 8; k++) begin
         drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
         tests++; if (imem_req !== 1'b1 || imem_addr !== 8'h40 + 8'(k - 1)) begin fails++; $display("FAIL redir_req[%0d]: got %b/%h want 1/%h", k, imem_req, imem_addr, 8'h40 + 8'(k - 1)); end
         tests++; if (instr_valid !== (k >= 3)) begin fails++; $display("FAIL redir_valid[%0d]: got %b want %b", k, instr_valid, k >= 3); end
         if (k >= 3) begin
            e = 8'h40 + 8'(k - 3);
            tests++; if (instr_pc !== e || instr !== word(e)) begin fails++; $display("FAIL redir_head[%0d]: got %h/%h want %h/%h", k, instr, instr_pc, word(e), e); end
         end
      end
      drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h80);
      drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h90);
      tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL b2b_req: got %b want 0", imem_req); end
      for (int k = 1; k <= 5; k++) begin
         drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
         tests++; if (imem_req !== 1'b1 || imem_addr !== 8'h90 + 8'(k - 1)) begin fails++; $display("FAIL b2b_addr[%0d]: got %b/%h want 1/%h", k, imem_req, imem_addr, 8'h90 + 8'(k - 1)); end
         tests++; if (instr_valid !== (k >= 3)) begin fails++; $display("FAIL b2b_valid[%0d]: got %b want %b", k, instr_valid, k >= 3); end
         if (k >= 3) begin
            e = 8'h90 + 8'(k - 3);
            tests++; if (instr_pc !== e || instr !== word(e)) begin fails++; $display("FAIL b2b_head[%0d]: got %h/%h want %h/%h", k, instr, instr_pc, word(e), e); end
         end
      end
   endtask

   task automatic test_halt();
      logic [7:0] e;
      for (int h = 0; h < 5; h++) begin
         drive(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
         tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL halt_req[%0d]: got %b want 0", h, imem_req); end
         tests++; if (instr_valid !== (h < 2)) begin fails++; $display("FAIL halt_valid[%0d]: got %b want %b", h, instr_valid, h < 2); end
         if (h < 2) begin
            e = 8'h93 + 8'(h);
            tests++; if (instr_pc !== e) begin fails++; $display("FAIL halt_head[%0d]: got %h want %h", h, instr_pc, e); end
         end
      end
      for (int u = 0; u < 5; u++) begin
         drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
         tests++; if (imem_req !== 1'b1 || imem_addr !== 8'h95 + 8'(u)) begin fails++; $display("FAIL resume_req[%0d]: got %b/%h want 1/%h", u, imem_req, imem_addr, 8'h95 + 8'(u)); end
         tests++; if (instr_valid !== (u >= 2)) begin fails++; $display("FAIL resume_valid[%0d]: got %b want %b", u, instr_valid, u >= 2); end
         if (u >= 2) begin
            e = 8'h95 + 8'(u - 2);
            tests++; if (instr_pc !== e || instr !== word(e)) begin fails++; $display("FAIL resume_head[%0d]: got %h/%h want %h/%h", u, instr, instr_pc, word(e), e); end
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] e;
      for (int i = 0; i < 2; i++) begin
         drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
         tests++; if (instr_valid !== 1'b1 || instr_pc !== 8'h98) begin fails++; $display("FAIL rmid_fill[%0d]: got %b/%h want 1/98", i, instr_valid, instr_pc); end
      end
      drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
      tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL rmid_req: got %b want 0", imem_req); end
      for (int k = 1; k <= 5; k++) begin
         drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
         tests++; if (imem_req !== 1'b1 || imem_addr !== RPC + 8'(k - 1)) begin fails++; $display("FAIL rmid_addr[%0d]: got %b/%h want 1/%h", k, imem_req, imem_addr, RPC + 8'(k - 1)); end
         tests++; if (instr_valid !== (k >= 3)) begin fails++; $display("FAIL rmid_valid[%0d]: got %b want %b", k, instr_valid, k >= 3); end
         if (k >= 3) begin
            e = RPC + 8'(k - 3);
            tests++; if (instr_pc !== e || instr !== word(e)) begin fails++; $display("FAIL rmid_head[%0d]: got %h/%h want %h/%h", k, instr, instr_pc, word(e), e); end
         end
      end
   endtask

   // Model: a queue of delivered (pc,instr) pairs plus at most one outstanding fetch.
   task automatic test_random();
      logic [26:0] mq[$];
      logic [26:0] hd;
      logic [7:0]  m_pc = RPC;
      logic        m_inf = 1'b0;
      logic [7:0]  m_inf_pc = 8'h00;
      logic        r, rdy, h, rd, e_valid, e_pop, e_req;
      logic [7:0]  rpc;
      int          occ;
      for (int i = 0; i < 2000; i++) begin
         r = (i == 0) || ($urandom_range(0, 199) == 0);
         rdy = ($urandom_range(0, 3) != 0);
         h = ($urandom_range(0, 7) == 0);
         rd = ($urandom_range(0, 19) == 0);
         rpc = 8'($urandom);
         drive(r, rdy, h, rd, rpc);
         e_valid = (mq.size() != 0);
         e_pop = e_valid && rdy;
         occ = mq.size() + int'(m_inf) - int'(e_pop);
         e_req = !r && !h && !rd && (occ < DEPTH);
         if (i > 0) begin
            tests++; if (imem_req !== e_req) begin fails++; $display("FAIL rnd_req[%0d]: got %b want %b", i, imem_req, e_req); end
            tests++; if (imem_addr !== m_pc) begin fails++; $display("FAIL rnd_addr[%0d]: got %h want %h", i, imem_addr, m_pc); end
            tests++; if (instr_valid !== e_valid) begin fails++; $display("FAIL rnd_valid[%0d]: got %b want %b", i, instr_valid, e_valid); end
            if (e_valid) begin
               hd = mq[0];
               tests++; if (instr_pc !== hd[26:19] || instr !== hd[18:0]) begin fails++; $display("FAIL rnd_head[%0d]: got %h/%h want %h/%h", i, instr, instr_pc, hd[18:0], hd[26:19]); end
            end
         end
         if (r) begin
            mq.delete(); m_pc = RPC; m_inf = 1'b0;
         end else begin
            if (e_pop) void'(mq.pop_front());
            if (m_inf && !rd) mq.push_back({m_inf_pc, word(m_inf_pc)});
            if (rd) mq.delete();
            m_inf = e_req;
            m_inf_pc = m_pc;
            if (rd) m_pc = rpc;
            else if (e_req) m_pc = m_pc + 8'd1;
         end
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; instr_ready = 1'b0; halt = 1'b0; redirect = 1'b0; redirect_pc = 8'h00;
      test_reset();
      test_backpressure();
      test_redirect();
      test_halt();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
